// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants used by the fetch, decode and execute stages.
package cpu_pkg;

  localparam int CPU_AW = 16;
  localparam int CPU_DW = 8;
  localparam logic [CPU_AW-1:0] CPU_RESET_PC = 16'h0000;

  // Occupancy counters need one extra bit so that a completely full queue is representable.
  function automatic int levelWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cpu_byte_fifo.sv
// Generic DEPTH x W circular buffer with push, pop, flush and an occupancy count.
// The head entry is read combinationally.
module cpu_byte_fifo
  import cpu_pkg::*;
#(
  parameter int W     = 24,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int LW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  // Flush takes priority; the pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push_i && !pop_i)      level_d = level_q + LW'(1);
      else if (pop_i && !push_i) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/cpu_fetch_queue.sv
// Instruction prefetch unit: fetches sequential bytes into a small queue tagged with their
// fetch address, yields the bus to execute, and flushes/restarts on a redirect.
module cpu_fetch_queue
  import cpu_pkg::*;
#(
  parameter int AW               = CPU_AW,
  parameter int DW               = CPU_DW,
  parameter int DEPTH            = 4,
  parameter logic [AW-1:0] RESET_PC = AW'(CPU_RESET_PC),
  localparam int LW              = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          bus_req,
  output logic [AW-1:0] bus_addr,
  input  logic          bus_grant,
  input  logic [DW-1:0] bus_rdata,
  output logic          dec_valid,
  output logic [DW-1:0] dec_byte,
  output logic [AW-1:0] dec_pc,
  input  logic          dec_ready,
  output logic [LW-1:0] fq_level
);

  logic [AW-1:0]    fetch_pc_q, fetch_pc_d;
  logic [LW-1:0]    fifo_level;
  logic [AW+DW-1:0] fifo_head;
  logic             push, pop;

  // Gating with rst_n keeps the bus request low for the whole time reset is held.
  assign bus_req   = rst_n && (fifo_level < LW'(DEPTH)) && !redirect_valid;
  assign push      = bus_req && bus_grant;
  assign dec_valid = (fifo_level != '0) && !redirect_valid;
  assign pop       = dec_valid && dec_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid)  fetch_pc_d = redirect_pc;
    else if (push)       fetch_pc_d = fetch_pc_q + AW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fetch_pc_q <= RESET_PC;
    else        fetch_pc_q <= fetch_pc_d;
  end

  cpu_byte_fifo #(
    .W     (AW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_valid),
    .push_i  (push),
    .wdata_i ({fetch_pc_q, bus_rdata}),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .level_o (fifo_level)
  );

  assign bus_addr = fetch_pc_q;
  assign dec_pc   = fifo_head[AW+DW-1:DW];
  assign dec_byte = fifo_head[DW-1:0];
  assign fq_level = fifo_level;

endmodule
